// File: rtl/spi_txn_ctrl_if.sv
// Bundle of host-side FIFO ports and SPI-master word handshake for spi_txn_ctrl.
// slave = the controller's view, master = the host/master side driving it.
interface spi_txn_ctrl_if #(
    parameter int p_WORD_LEN = 8
);
    logic [p_WORD_LEN-1:0] tx_data;
    logic                  tx_last;
    logic                  tx_en;
    logic                  tx_rdy;
    logic [p_WORD_LEN-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_en;
    logic                  rx_ovf;
    logic                  rx_ovf_clr;
    logic                  o_cs_n;
    logic                  o_busy;
    logic [p_WORD_LEN-1:0] m_inp_data;
    logic                  m_inp_en;
    logic                  m_inp_rdy;
    logic [p_WORD_LEN-1:0] m_out_data;
    logic                  m_out_rdy;

    modport slave (
        input  tx_data, tx_last, tx_en, rx_en, rx_ovf_clr,
        input  m_inp_rdy, m_out_data, m_out_rdy,
        output tx_rdy, rx_data, rx_valid, rx_ovf, o_cs_n, o_busy,
        output m_inp_data, m_inp_en
    );

    modport master (
        output tx_data, tx_last, tx_en, rx_en, rx_ovf_clr,
        output m_inp_rdy, m_out_data, m_out_rdy,
        input  tx_rdy, rx_data, rx_valid, rx_ovf, o_cs_n, o_busy,
        input  m_inp_data, m_inp_en
    );
endinterface

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: TX/RX word FIFOs plus a CS-framing FSM that
// feeds the SPI master one word at a time and captures each returned word.
module spi_txn_ctrl #(
    parameter int p_WORD_LEN   = 8,
    parameter int p_FIFO_DEPTH = 16,
    parameter int p_CS_SETUP   = 4,
    parameter int p_CS_HOLD    = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    spi_txn_ctrl_if.slave bus
);
    localparam int PW      = $clog2(p_FIFO_DEPTH);
    localparam int CW      = $clog2(p_FIFO_DEPTH + 1);
    localparam int CNT_MAX = (p_CS_SETUP > p_CS_HOLD) ? p_CS_SETUP : p_CS_HOLD;
    localparam int TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_HOLD
    } state_t;

    // ---------------- TX FIFO: {last, data} ----------------
    logic [p_WORD_LEN:0]   tx_mem [p_FIFO_DEPTH];
    logic [PW-1:0]         tx_wp, tx_rp;
    logic [CW-1:0]         tx_cnt;
    logic                  tx_full, tx_empty, tx_push, tx_pop;
    logic [p_WORD_LEN:0]   tx_head;

    assign tx_full  = (tx_cnt == CW'(p_FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = bus.tx_en && !tx_full;
    assign tx_head  = tx_mem[tx_rp];

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wp] <= {bus.tx_last, bus.tx_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [p_WORD_LEN-1:0] rx_mem [p_FIFO_DEPTH];
    logic [PW-1:0]         rx_wp, rx_rp;
    logic [CW-1:0]         rx_cnt;
    logic                  rx_full, rx_empty, rx_push, rx_pop, rx_acc;
    logic                  rx_ovf_q;

    assign rx_full  = (rx_cnt == CW'(p_FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = bus.rx_en && !rx_empty;
    // a simultaneous pop frees the slot, so a full FIFO can still accept
    assign rx_acc   = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge i_clk) begin
        if (rx_acc) rx_mem[rx_wp] <= bus.m_out_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt   <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (rx_acc) rx_wp <= rx_wp + PW'(1);
            if (rx_pop) rx_rp <= rx_rp + PW'(1);
            case ({rx_acc, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_push && !rx_acc)  rx_ovf_q <= 1'b1;
            else if (bus.rx_ovf_clr) rx_ovf_q <= 1'b0;
        end
    end

    // ---------------- framing FSM ----------------
    state_t                state_q, state_d;
    logic                  cs_n_q, cs_n_d;
    logic                  en_q, en_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            en_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            en_q    <= en_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        en_d    = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                if (!tx_empty) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == TW'(p_CS_SETUP - 1)) state_d = S_ISSUE;
                else                              cnt_d   = cnt_q + TW'(1);
            end
            // an empty FIFO here just stalls with CS still low
            S_ISSUE: begin
                if (bus.m_inp_rdy && !tx_empty) begin
                    data_d  = tx_head[p_WORD_LEN-1:0];
                    en_d    = 1'b1;
                    tx_pop  = 1'b1;
                    last_d  = tx_head[p_WORD_LEN];
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!bus.m_inp_rdy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.m_out_rdy) begin
                    rx_push = 1'b1;
                    cnt_d   = '0;
                    state_d = last_q ? S_HOLD : S_ISSUE;
                end
            end
            S_HOLD: begin
                if (cnt_q == TW'(p_CS_HOLD - 1)) begin
                    cs_n_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    assign bus.tx_rdy     = !tx_full;
    assign bus.rx_valid   = !rx_empty;
    assign bus.rx_data    = rx_empty ? '0 : rx_mem[rx_rp];
    assign bus.rx_ovf     = rx_ovf_q;
    assign bus.o_cs_n     = cs_n_q;
    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.m_inp_data = data_q;
    assign bus.m_inp_en   = en_q;
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed + randomized bench for spi_txn_ctrl with a behavioural SPI master
// and queue-based expectations for issued words, RX contents and CS framing.
module tb_spi_txn_ctrl;
    localparam int WL    = 8;
    localparam int DEPTH = 16;
    localparam int SETUP = 4;
    localparam int HOLD  = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    spi_txn_ctrl_if #(.p_WORD_LEN(WL)) bus ();

    spi_txn_ctrl #(
        .p_WORD_LEN(WL), .p_FIFO_DEPTH(DEPTH), .p_CS_SETUP(SETUP), .p_CS_HOLD(HOLD)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WL-1:0] exp_tx [$];
    logic [WL-1:0] exp_rx [$];
    logic [WL-1:0] resp_q [$];
    logic          exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural SPI master (never reset) ----------------
    logic          mst_idle  = 1'b1;
    logic          mst_hold  = 1'b0;
    int            mst_cnt   = 0;
    logic [WL-1:0] mst_resp  = '0;

    assign bus.m_inp_rdy = mst_idle && !mst_hold;
    assign bus.m_out_rdy = bus.m_inp_rdy;

    // slave reply for an accepted word; also enters it into the RX model
    function automatic logic [WL-1:0] accept_word();
        logic [WL-1:0] r;
        r = (resp_q.size() != 0) ? resp_q.pop_front() : WL'($urandom);
        if (exp_rx.size() == DEPTH) exp_ovf = 1'b1;
        else                        exp_rx.push_back(r);
        return r;
    endfunction

    always @(posedge i_clk) begin
        if (mst_idle) begin
            if (bus.m_inp_en && !mst_hold) begin
                mst_idle <= 1'b0;
                mst_cnt  <= int'($urandom_range(3, 8));
                mst_resp <= accept_word();
            end
        end else if (mst_cnt == 0) begin
            mst_idle       <= 1'b1;
            bus.m_out_data <= mst_resp;
        end else begin
            mst_cnt <= mst_cnt - 1;
        end
    end

    // ---------------- monitor ----------------
    int   frames = 0, issued = 0, gap = 0, first_gap = 0, frame_words = 0;
    logic prev_cs = 1'b1, prev_en = 1'b0;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (prev_cs && !bus.o_cs_n) begin
                frames++;
                gap = 0;
                frame_words = 0;
            end else if (!bus.o_cs_n) begin
                gap++;
            end
            if (bus.m_inp_en) begin
                issued++;
                if (frame_words == 0) first_gap = gap;
                frame_words++;
                chk("en_cs_low", bus.o_cs_n, 0);
                chk("en_rdy", bus.m_inp_rdy, 1);
                chk("en_width", prev_en, 0);
                if (exp_tx.size() == 0) chk("issue_unexpected", bus.m_inp_en, 0);
                else                    chk("issue_data", bus.m_inp_data, exp_tx.pop_front());
            end
        end
        prev_cs = bus.o_cs_n;
        prev_en = bus.m_inp_en;
    end

    // ---------------- host helpers ----------------
    task automatic push_word(input logic [WL-1:0] d, input logic l);
        int t = 0;
        while (!bus.tx_rdy && t < 1000) begin @(negedge i_clk); t++; end
        if (!bus.tx_rdy) chk("push_timeout", bus.tx_rdy, 1);
        bus.tx_data = d;
        bus.tx_last = l;
        bus.tx_en   = 1'b1;
        exp_tx.push_back(d);
        @(negedge i_clk);
        bus.tx_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int run = 0, t = 0;
        while (run < 3 && t < 5000) begin
            @(negedge i_clk);
            t++;
            if (!bus.o_busy && bus.m_inp_rdy) run++;
            else                              run = 0;
        end
        if (run < 3) chk({tag, "_idle_timeout"}, bus.o_busy, 0);
        #1;
    endtask

    task automatic drain_rx(input string tag);
        int n = 0;
        int n_exp;
        n_exp = exp_rx.size();
        while (bus.rx_valid && n < 64) begin
            if (exp_rx.size() == 0) chk({tag, "_rx_extra"}, bus.rx_valid, 0);
            else                    chk({tag, "_rx_data"}, bus.rx_data, exp_rx.pop_front());
            bus.rx_en = 1'b1;
            @(negedge i_clk);
            bus.rx_en = 1'b0;
            n++;
        end
        chk({tag, "_rx_count"}, n, n_exp);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, i0, k, t;
        bus.tx_data = '0; bus.tx_last = 1'b0; bus.tx_en = 1'b0;
        bus.rx_en = 1'b0; bus.rx_ovf_clr = 1'b0;
        repeat (3) @(negedge i_clk);

        // reset state
        chk("rst_cs_n", bus.o_cs_n, 1);
        chk("rst_m_inp_en", bus.m_inp_en, 0);
        chk("rst_m_inp_data", bus.m_inp_data, 0);
        chk("rst_rx_ovf", bus.rx_ovf, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_tx_rdy", bus.tx_rdy, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // single word 0xA5 -> 0x3C
        f0 = frames; i0 = issued;
        resp_q.push_back(8'h3C);
        push_word(8'hA5, 1'b1);
        t = 0;
        while (!bus.rx_valid && t < 500) begin @(negedge i_clk); t++; end
        chk("t1_rx_valid", bus.rx_valid, 1);
        chk("t1_rx_data", bus.rx_data, 8'h3C);
        k = 0;
        while (!bus.o_cs_n && k < 100) begin @(negedge i_clk); k++; end
        chk("t1_hold_cycles", k, HOLD);
        wait_idle("t1");
        chk("t1_setup_gap", first_gap, SETUP + 1);
        chk("t1_frames", frames - f0, 1);
        chk("t1_issued", issued - i0, 1);
        drain_rx("t1");

        // three-word transaction in one frame
        f0 = frames; i0 = issued;
        push_word(8'h01, 1'b0);
        push_word(8'h02, 1'b0);
        push_word(8'h03, 1'b1);
        wait_idle("t2");
        chk("t2_frames", frames - f0, 1);
        chk("t2_issued", issued - i0, 3);
        drain_rx("t2");

        // slow feed: stall in ISSUE with CS low
        f0 = frames; i0 = issued;
        push_word(8'h11, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge i_clk);
            if (c % 50 == 0) begin
                chk("t3_stall_cs", bus.o_cs_n, 0);
                chk("t3_stall_busy", bus.o_busy, 1);
                chk("t3_stall_en", bus.m_inp_en, 0);
            end
        end
        push_word(8'h22, 1'b1);
        wait_idle("t3");
        chk("t3_frames", frames - f0, 1);
        chk("t3_issued", issued - i0, 2);
        drain_rx("t3");

        // FIFO limits: fill TX with master held off, then overflow RX
        f0 = frames; i0 = issued;
        mst_hold = 1'b1;
        for (int w = 0; w < DEPTH; w++) push_word(WL'($urandom), 1'b1);
        chk("t4_tx_full", bus.tx_rdy, 0);
        bus.tx_data = 8'hEE; bus.tx_last = 1'b1; bus.tx_en = 1'b1;
        @(negedge i_clk);
        bus.tx_en = 1'b0;
        chk("t4_tx_still_full", bus.tx_rdy, 0);
        mst_hold = 1'b0;
        push_word(WL'($urandom), 1'b1);
        wait_idle("t4");
        chk("t4_frames", frames - f0, DEPTH + 1);
        chk("t4_issued", issued - i0, DEPTH + 1);
        chk("t4_ovf_set", bus.rx_ovf, exp_ovf);
        drain_rx("t4");
        chk("t4_ovf_sticky", bus.rx_ovf, 1);
        bus.rx_ovf_clr = 1'b1;
        @(negedge i_clk);
        bus.rx_ovf_clr = 1'b0;
        chk("t4_ovf_clr", bus.rx_ovf, 0);

        // back-to-back single-word transactions -> two frames
        f0 = frames; i0 = issued;
        push_word(8'h10, 1'b1);
        push_word(8'h20, 1'b1);
        wait_idle("t5");
        chk("t5_frames", frames - f0, 2);
        chk("t5_issued", issued - i0, 2);
        drain_rx("t5");

        // reset during WAIT_DONE of a 2-word transaction
        i0 = issued;
        push_word(8'h55, 1'b0);
        push_word(8'h66, 1'b1);
        t = 0;
        while (!((issued - i0) == 1 && !bus.m_inp_rdy) && t < 500) begin
            @(negedge i_clk); t++;
        end
        chk("t6_reached_busy", bus.m_inp_rdy, 0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_cs_n", bus.o_cs_n, 1);
        chk("t6_rst_busy", bus.o_busy, 0);
        chk("t6_rst_tx_rdy", bus.tx_rdy, 1);
        chk("t6_rst_rx_valid", bus.rx_valid, 0);
        chk("t6_rst_m_inp_en", bus.m_inp_en, 0);
        exp_tx.delete();
        exp_rx.delete();
        resp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        t = 0;
        while (!bus.m_inp_rdy && t < 100) begin @(negedge i_clk); t++; end
        repeat (3) @(negedge i_clk);
        chk("t6_no_stale_rx", bus.rx_valid, 0);
        chk("t6_idle_after", bus.o_busy, 0);
        f0 = frames; i0 = issued;
        resp_q.push_back(8'h81);
        push_word(8'h9A, 1'b1);
        wait_idle("t6");
        chk("t6_frames", frames - f0, 1);
        chk("t6_issued", issued - i0, 1);
        drain_rx("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
